// File: rtl/intersection_scheduler_if.sv
// Request and signal-head bundle between the intersection sensors/heads and the phase scheduler.
interface intersection_scheduler_if;
    logic       ped_req;
    logic       up_req;
    logic       down_req;
    logic       turn_req;
    logic       pedestrian_green;
    logic       up_green;
    logic       down_green;
    logic       turn_green;
    logic       all_red;
    logic [1:0] phase;
    logic       ped_served;

    modport master (
        output ped_req, up_req, down_req, turn_req,
        input  pedestrian_green, up_green, down_green, turn_green, all_red, phase, ped_served
    );

    modport slave (
        input  ped_req, up_req, down_req, turn_req,
        output pedestrian_green, up_green, down_green, turn_green, all_red, phase, ped_served
    );
endinterface

// File: rtl/intersection_scheduler.sv
// Round-robin phase controller (UD, UT, PED) with min/max green dwell and all-red clearance.
module intersection_scheduler #(
    parameter int GREEN_MIN    = 4,
    parameter int GREEN_MAX    = 12,
    parameter int CLEAR_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    intersection_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_GREEN = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    localparam logic [1:0]       PH_UD  = 2'd0;
    localparam logic [1:0]       PH_UT  = 2'd1;
    localparam logic [1:0]       PH_PED = 2'd2;
    localparam logic [1:0]       PH_CLR = 2'd3;
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] GMIN    = CNT_W'(GREEN_MIN);
    localparam logic [CNT_W-1:0] GMAX    = CNT_W'(GREEN_MAX);
    localparam logic [CNT_W-1:0] CLR_LEN = CNT_W'(CLEAR_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Pending/request vectors are ordered {PED, UT, UD}.
    function automatic logic [2:0] ph_mask(input logic [1:0] ph);
        logic [2:0] m;
        case (ph)
            PH_UD:   m = 3'b001;
            PH_UT:   m = 3'b010;
            PH_PED:  m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

    function automatic logic [1:0] rr_succ(input logic [1:0] ph);
        logic [1:0] s;
        case (ph)
            PH_UD:   s = PH_UT;
            PH_UT:   s = PH_PED;
            default: s = PH_UD;
        endcase
        return s;
    endfunction

    // The phase just served is checked last so a fresh request for it cannot starve the others.
    function automatic logic [1:0] rr_pick(input logic [1:0] prev, input logic [2:0] pend);
        logic [1:0] c1;
        logic [1:0] c2;
        logic [1:0] pick;
        c1 = rr_succ(prev);
        c2 = rr_succ(c1);
        if (|(pend & ph_mask(c1))) begin
            pick = c1;
        end else if (|(pend & ph_mask(c2))) begin
            pick = c2;
        end else if (|(pend & ph_mask(prev))) begin
            pick = prev;
        end else begin
            pick = PH_UD;
        end
        return pick;
    endfunction

    // Greens as {pedestrian, up, down, turn}.
    function automatic logic [3:0] greens_of(input logic [1:0] ph);
        logic [3:0] g;
        case (ph)
            PH_UD:   g = 4'b0110;
            PH_UT:   g = 4'b0101;
            PH_PED:  g = 4'b1000;
            default: g = 4'b0000;
        endcase
        return g;
    endfunction

    state_e           state_q;
    logic [1:0]       cur_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       pend_q;
    logic [3:0]       greens_q;
    logic             all_red_q;
    logic [1:0]       phase_q;
    logic             ped_served_q;

    logic [2:0]       req_s;
    logic [2:0]       own_green_s;
    logic [2:0]       pend_set_s;
    logic [2:0]       pend_d;
    logic             other_pend_s;
    logic             own_active_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             exit_s;
    logic             enter_s;
    logic [1:0]       enter_ph_s;

    // Next-state decisions: pending update, green exit and green entry.
    always_comb begin
        req_s        = {bus.ped_req, bus.turn_req, bus.up_req | bus.down_req};
        own_green_s  = (state_q == ST_GREEN) ? ph_mask(cur_q) : 3'b000;
        pend_set_s   = pend_q | (req_s & ~own_green_s);
        other_pend_s = |(pend_q & ~own_green_s);
        own_active_s = |(req_s & own_green_s);
        cnt_inc_s    = (cnt_q == CNT_SAT) ? cnt_q : (cnt_q + CNT_ONE);
        exit_s       = 1'b0;
        enter_s      = 1'b0;
        enter_ph_s   = PH_UD;
        case (state_q)
            ST_INIT: begin
                enter_s    = (cnt_inc_s >= CLR_LEN);
                enter_ph_s = PH_UD;
            end
            ST_GREEN: begin
                exit_s = other_pend_s && (cnt_q >= GMIN) && (!own_active_s || (cnt_q >= GMAX));
            end
            ST_CLEAR: begin
                enter_s    = (cnt_q >= CLR_LEN);
                enter_ph_s = rr_pick(cur_q, pend_set_s);
            end
            default: begin
                enter_s = 1'b0;
            end
        endcase
        if (enter_s) begin
            pend_d = pend_set_s & ~ph_mask(enter_ph_s);
        end else begin
            pend_d = pend_set_s;
        end
    end

    // Phase FSM with registered signal-head outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_INIT;
            cur_q        <= PH_UD;
            cnt_q        <= '0;
            pend_q       <= 3'b000;
            greens_q     <= 4'b0000;
            all_red_q    <= 1'b1;
            phase_q      <= PH_CLR;
            ped_served_q <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            ped_served_q <= 1'b0;
            case (state_q)
                ST_INIT, ST_CLEAR: begin
                    if (enter_s) begin
                        state_q      <= ST_GREEN;
                        cur_q        <= enter_ph_s;
                        cnt_q        <= CNT_ONE;
                        greens_q     <= greens_of(enter_ph_s);
                        all_red_q    <= 1'b0;
                        phase_q      <= enter_ph_s;
                        ped_served_q <= (enter_ph_s == PH_PED);
                    end else begin
                        cnt_q <= cnt_inc_s;
                    end
                end
                ST_GREEN: begin
                    if (exit_s) begin
                        state_q   <= ST_CLEAR;
                        cnt_q     <= CNT_ONE;
                        greens_q  <= 4'b0000;
                        all_red_q <= 1'b1;
                        phase_q   <= PH_CLR;
                    end else begin
                        cnt_q <= cnt_inc_s;
                    end
                end
                default: begin
                    state_q   <= ST_INIT;
                    cnt_q     <= '0;
                    greens_q  <= 4'b0000;
                    all_red_q <= 1'b1;
                    phase_q   <= PH_CLR;
                end
            endcase
        end
    end

    assign bus.pedestrian_green = greens_q[3];
    assign bus.up_green         = greens_q[2];
    assign bus.down_green       = greens_q[1];
    assign bus.turn_green       = greens_q[0];
    assign bus.all_red          = all_red_q;
    assign bus.phase            = phase_q;
    assign bus.ped_served       = ped_served_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed and randomized bench for intersection_scheduler against a cycle-level behavioural model.
module tb_intersection_scheduler;

    localparam int GMIN = 4;
    localparam int GMAX = 12;
    localparam int CLR  = 2;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    intersection_scheduler_if bus ();

    intersection_scheduler #(
        .GREEN_MIN    (GMIN),
        .GREEN_MAX    (GMAX),
        .CLEAR_CYCLES (CLR),
        .CNT_W        (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: mode 0 = startup all-red, 1 = green, 2 = clearance.
    int m_mode;
    int m_ph;
    int m_dwell;
    int m_left;
    bit m_pend [3];
    bit m_served;

    task automatic model_step(input bit r, input bit p, input bit u, input bit d, input bit t);
        bit req [3];
        bit np [3];
        bit other;
        int nxt;
        int cand;
        req[0] = u | d;
        req[1] = t;
        req[2] = p;
        if (!r) begin
            m_mode = 0; m_left = CLR; m_ph = 0; m_dwell = 0; m_served = 1'b0;
            for (int k = 0; k < 3; k++) m_pend[k] = 1'b0;
            return;
        end
        m_served = 1'b0;
        for (int k = 0; k < 3; k++) np[k] = m_pend[k] | (req[k] && !(m_mode == 1 && m_ph == k));
        nxt = -1;
        if (m_mode == 0) begin
            m_left--;
            if (m_left == 0) nxt = 0;
        end else if (m_mode == 1) begin
            other = 1'b0;
            for (int k = 0; k < 3; k++) if (k != m_ph && m_pend[k]) other = 1'b1;
            if (other && m_dwell >= GMIN && (!req[m_ph] || m_dwell >= GMAX)) begin
                m_mode = 2;
                m_left = CLR;
            end else if (m_dwell < 255) begin
                m_dwell++;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                nxt = 0;
                for (int s = 1; s <= 3; s++) begin
                    cand = (m_ph + s) % 3;
                    if (np[cand]) begin
                        nxt = cand;
                        break;
                    end
                end
            end
        end
        if (nxt >= 0) begin
            m_mode   = 1;
            m_ph     = nxt;
            m_dwell  = 1;
            np[nxt]  = 1'b0;
            m_served = (nxt == 2);
        end
        for (int k = 0; k < 3; k++) m_pend[k] = np[k];
    endtask

    function automatic logic [7:0] model_out();
        logic [7:0] v;
        if (m_mode == 1) begin
            v = {(m_ph == 2), (m_ph != 2), (m_ph == 0), (m_ph == 1), 1'b0, 2'(m_ph), m_served};
        end else begin
            v = 8'b0000_1110;
        end
        return v;
    endfunction

    task automatic cyc(input bit r, input bit p, input bit u, input bit d, input bit t, input string tag);
        logic [7:0] obs;
        logic [7:0] exp_v;
        logic       inv_ok;
        reset        = r;
        bus.ped_req  = p;
        bus.up_req   = u;
        bus.down_req = d;
        bus.turn_req = t;
        @(posedge clock);
        model_step(r, p, u, d, t);
        #1;
        obs   = {bus.pedestrian_green, bus.up_green, bus.down_green, bus.turn_green,
                 bus.all_red, bus.phase, bus.ped_served};
        exp_v = model_out();
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed {ped,up,dn,turn,allred,phase,served}=%b expected %b at %0t", tag, obs, exp_v, $time);
        end
        inv_ok = !(bus.pedestrian_green && (bus.up_green || bus.down_green || bus.turn_green))
                 && !(bus.down_green && bus.turn_green)
                 && (bus.all_red == !(bus.pedestrian_green || bus.up_green || bus.down_green || bus.turn_green));
        checks++;
        assert (inv_ok === 1'b1) else begin
            errors++;
            $error("FAIL %s_invariant: observed %b expected 1 at %0t", tag, inv_ok, $time);
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.ped_req = 1'b0; bus.up_req = 1'b0; bus.down_req = 1'b0; bus.turn_req = 1'b0;

        // Startup clearance then UD rest.
        do_reset(3);
        idle(52, "startup_rest");

        // Pedestrian pulse at the first UD cycle.
        do_reset(1);
        idle(2, "init_clear");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "ped_pulse");
        idle(14, "ped_serve");

        // Up held, turn pulsed at first UD cycle: max-out at GREEN_MAX.
        do_reset(2);
        idle(2, "init_clear2");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "turn_pulse_up_held");
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "up_held");
        idle(6, "ut_rest");

        // Turn pulse while UT green is ignored.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "turn_in_ut");
        idle(10, "ut_still_rest");

        // Ped and turn together from UD: UT first, then PED.
        do_reset(1);
        idle(8, "ud_rest");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "ped_turn_same");
        idle(20, "rr_order");

        // Reset in the middle of PED green; a ped request before it is lost.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "ped_in_ped");
        do_reset(2);
        idle(12, "after_mid_reset");

        // Randomized traffic with rare resets.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 299) != 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 9) == 0),
                "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/intersection_scheduler.md
Name: intersection_scheduler

Overview:
- Phase controller driving the four green outputs of the intersection: pedestrian_green, up_green, down_green and turn_green.
- Latches requests from the vehicle sensors and the pedestrian button.
- Serves three non-conflicting phases round-robin, with minimum and maximum green times and an all-red clearance interval between phases.
- Its outputs feed the intersection's signal heads and are the signals the formal cover/assert checkers bind to.

Parameters:
- GREEN_MIN, 4: minimum green dwell in cycles (>=1).
- GREEN_MAX, 12: maximum green dwell in cycles when another phase is pending (>=GREEN_MIN).
- CLEAR_CYCLES, 2: all-red clearance length in cycles (>=1).
- CNT_W, 8: dwell/clearance counter width; all three parameters must be < 2**CNT_W.

Ports:
- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset: sampled low at a rising edge, all state and outputs take their reset values.
- ped_req  input  1  pedestrian button (level or pulse).
- up_req  input  1  up-direction vehicle sensor.
- down_req  input  1  down-direction vehicle sensor.
- turn_req  input  1  turn-lane vehicle sensor.
- pedestrian_green  output  1  pedestrian walk.
- up_green  output  1  up-direction green.
- down_green  output  1  down-direction green.
- turn_green  output  1  turn green.
- all_red  output  1  clearance/startup indicator; high when no green is asserted.
- phase  output  2  0 = UD, 1 = UT, 2 = PED, 3 = clearance.
- ped_served  output  1  one-cycle pulse in the first cycle pedestrian_green is high.

Behaviour:
- All outputs are registered.
- Reset values: all greens 0, all_red 1, phase 3, ped_served 0. Pending bits and counters are cleared.

Phases:
- UD: up_green and down_green.
- UT: up_green and turn_green.
- PED: pedestrian_green only.

Invariants:
- pedestrian_green is never high together with any vehicle green.
- down_green and turn_green are never both high.
- all_red == ~(any green).

States:
- INIT_CLEAR: entered on reset.
  - Holds all-red for exactly CLEAR_CYCLES cycles after reset deasserts.
  - Then enters GREEN(UD). UD is the resting phase.
- GREEN(p): dwell counter starts at 1 in the first green cycle and increments by one per green cycle, saturating.
  - Other-phase-pending is true when any phase other than p has a pending bit set.
  - Exit to CLEAR when other-phase-pending && dwell >= GREEN_MIN && (own_active == 0 || dwell >= GREEN_MAX).
  - own_active per phase: UD = up_req | down_req; UT = turn_req; PED = ped_req.
  - With no other phase pending, stay in GREEN(p) indefinitely. There is no max-out without a competitor.
- CLEAR: greens low, all_red 1, phase 3 for exactly CLEAR_CYCLES cycles.
  - At its end, latch the next phase: the first pending phase in round-robin order after the previous phase (UD -> UT -> PED -> UD).
  - Enter GREEN(next).
  - Green visibly changes one cycle after the exit decision.

Pending bits:
- ud_pend is set by up_req | down_req; ut_pend by turn_req; ped_pend by ped_req.
- A request is ignored, and does not set pending, while its phase is green.
- A pending bit clears on the cycle its phase enters GREEN. Clear wins over a simultaneous set for that phase.
- Requests arriving during CLEAR are latched and take part in next-phase selection at CLEAR's last cycle.
- Simultaneous requests for several phases are resolved by round-robin order only.

Other rules:
- Reset mid-green or mid-clear: outputs go to reset values at that edge, then the INIT_CLEAR sequence runs.
- Counters saturate at 2**CNT_W-1 and never wrap.

Test Plan:
- Reset low 3 cycles, then high, no requests -> all_red=1 and phase=3 for exactly 2 cycles, then up_green=down_green=1, phase=0, held for 50 cycles.
- In UD rest, one-cycle ped_req pulse, up/down idle -> UD green lasts 4 cycles from its start (or ends immediately if already >=4), then 2 cycles all-red, then pedestrian_green=1 with ped_served high exactly 1 cycle; no vehicle green while pedestrian_green=1.
- In UD, up_req held high continuously, turn_req pulsed at the first UD cycle -> UD green held exactly 12 cycles, 2 cycles all_red, then UT (up_green=turn_green=1, down_green=0).
- From UD, ped_req and turn_req asserted in the same cycle -> UT served first, then PED after another 2-cycle clearance (round-robin order).
- turn_req pulsed while UT green -> ut_pend stays clear; UT remains resting with no extra clearance.
- Reset asserted (low) in the middle of a PED green -> next edge all greens 0, phase=3; after release, 2 all-red cycles, then UD. A ped_req issued before the reset is lost.
